case_4_acc_frame: RTL and testbench
===================================

# case_4_acc_frame

Frame accumulator directly downstream of the case_4 7×2 signed multiplier. It consumes the 9-bit signed products over a valid/ready stream and sums each frame of up to FRAME_LEN products. Each frame sum is presented as one registered result under a valid/ready handshake. Frames end on `in_last` or on reaching FRAME_LEN beats, whichever comes first.

## Interface
- PROD_WIDTH, 9, signed input product width (multiplier dout)
- ACC_WIDTH, 16, signed accumulator and result width; must be ≥ PROD_WIDTH
- FRAME_LEN, 8, maximum beats per frame (≥1); counter width clog2(FRAME_LEN+1)

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst_n  in  1  synchronous active-low reset
- in_data  in  PROD_WIDTH  signed product
- in_valid  in  1  in_data valid
- in_last  in  1  final beat of frame (qualified by in_valid)
- in_ready  out  1  block accepts a beat this cycle
- out_data  out  ACC_WIDTH  signed frame sum
- out_sat  out  1  sticky: a clamp occurred in this frame
- out_beats  out  clog2(FRAME_LEN+1)  beats summed in this frame
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result

## Operation
- FSM states:
  - ACCUM: reset state; accepting beats.
  - HOLD: result registered, waiting for downstream.
- in_ready = (state == ACCUM). out_valid = (state == HOLD).
- Beat accept: in_valid & in_ready.
  - in_data is sign-extended to ACC_WIDTH+1 and added to acc.
  - The sum is clamped (see Configuration).
  - cnt increments.
- Frame end: the accepted beat has in_last = 1 or cnt+1 == FRAME_LEN.
  - The final sum goes to out_data, cnt+1 goes to out_beats, and the frame sat flag goes to out_sat.
  - acc, cnt and the sat flag clear. State → HOLD.
- in_last and the FRAME_LEN limit in the same cycle close one frame only; no empty frame follows.
- HOLD:
  - out_data, out_sat and out_beats stay stable while out_valid & !out_ready.
  - out_valid & out_ready returns the FSM to ACCUM the next cycle.
  - No beats are accepted in HOLD, so there is one bubble cycle per frame.
- in_valid low mid-frame: acc and cnt hold. No timeout.
- Empty frames are impossible: a frame needs at least one accepted beat.

## Timing
- Reset values (ap_rst_n low at an edge):
  - state = ACCUM, acc = 0, cnt = 0, sat = 0.
  - out_data = 0, out_beats = 0, out_sat = 0, out_valid = 0, in_ready = 1 from the first cycle after reset.
- Reset mid-frame or in HOLD discards the partial frame or the pending result. Nothing is emitted.
- Latency: out_valid asserts on the cycle after the edge that accepts the final beat.
- Throughput: one beat per cycle within a frame. Minimum frame period is beats+1 cycles with out_ready held high.
- in_ready depends only on state (registered); it has no combinational path from out_ready.

## Configuration
- CASE4_ACC_SAT_EN defined:
  - The per-beat sum is clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
  - Any clamp sets the frame's sticky sat flag, reported on out_sat.
- Not defined:
  - The sum wraps two's-complement at ACC_WIDTH.
  - out_sat is constant 0, and the clamp logic and sat register are absent.

## Test plan
- Reset, then 8 beats of +127 with in_last low (FRAME_LEN=8) → one cycle after the 8th accept: out_valid=1, out_data=1016, out_beats=8, out_sat=0, in_ready=0.
- Beats −254, +100, −3 with in_last on the 3rd → out_data=−157, out_beats=3. Hold out_ready low for 5 cycles → outputs stable, in_ready=0, no beats accepted. Then out_ready=1 → in_ready=1 the next cycle.
- ACC_WIDTH=10, CASE4_ACC_SAT_EN defined: beats −254, −254, −254, +127 with last → out_data=−385 (−512 clamp, then +127), out_sat=1.
- Same stimulus without the macro → out_data = wrapped value 389 (−762 wraps to 262, then +127 = 389), out_sat=0.
- in_last on the 8th beat with FRAME_LEN=8 → exactly one result, out_beats=8. The next beat starts a fresh frame with acc=0.
- Pulse ap_rst_n low after 3 beats of +10, then send 2 beats of +5 with last → out_data=10, out_beats=2. No result is emitted for the aborted frame.

Source files
------------

// File: rtl/case_4_acc_frame.sv
// Frame accumulator for the case_4 multiplier products; one registered sum per frame, 1-cycle latency.
// Backpressure: holds the result until out_ready, accepts no beats meanwhile. Optional clamp: CASE4_ACC_SAT_EN.
module case_4_acc_frame #(
    parameter int PROD_WIDTH = 9,
    parameter int ACC_WIDTH  = 16,
    parameter int FRAME_LEN  = 8
) (
    input  logic                                  ap_clk,
    input  logic                                  ap_rst_n,
    input  logic signed [PROD_WIDTH-1:0]          in_data,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    output logic                                  in_ready,
    output logic signed [ACC_WIDTH-1:0]           out_data,
    output logic                                  out_sat,
    output logic [$clog2(FRAME_LEN+1)-1:0]        out_beats,
    output logic                                  out_valid,
    input  logic                                  out_ready
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                      r_state;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]            r_cnt;
    logic signed [ACC_WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0]            r_out_beats;
    logic signed [ACC_WIDTH-1:0] w_next;
    logic [CNT_W-1:0]            w_cnt_inc;
    logic                        w_end;

`ifdef CASE4_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] w_sum;
    logic                      w_clamp;
    logic                      r_sat;
    logic                      r_out_sat;

    // One guard bit: overflow shows as disagreement between the top two bits.
    assign w_sum   = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(in_data);
    assign w_clamp = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    assign w_next  = !w_clamp ? w_sum[ACC_WIDTH-1:0] : (w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
    assign out_sat = r_out_sat;
`else
    assign w_next  = r_acc + ACC_WIDTH'(in_data);
    assign out_sat = 1'b0;
`endif

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_end     = in_last || (w_cnt_inc == CNT_W'(FRAME_LEN));

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign out_beats = r_out_beats;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_beats <= '0;
`ifdef CASE4_ACC_SAT_EN
            r_sat       <= 1'b0;
            r_out_sat   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        if (w_end) begin
                            r_out_data  <= w_next;
                            r_out_beats <= w_cnt_inc;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_state     <= HOLD;
`ifdef CASE4_ACC_SAT_EN
                            r_out_sat   <= r_sat | w_clamp;
                            r_sat       <= 1'b0;
`endif
                        end else begin
                            r_acc <= w_next;
                            r_cnt <= w_cnt_inc;
`ifdef CASE4_ACC_SAT_EN
                            r_sat <= r_sat | w_clamp;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) r_state <= ACCUM;
                end
                default: r_state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_case_4_acc_frame.sv
// Bench for case_4_acc_frame: two instances (ACC_WIDTH 16 and 10) share one stimulus stream
// and are checked every cycle against an integer frame-sum model.
module tb_case_4_acc_frame;
    localparam int FRAME_LEN = 8;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic signed [8:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b0;

    logic               in_ready16, out_valid16, out_sat16;
    logic signed [15:0] out_data16;
    logic [3:0]         out_beats16;
    logic               in_ready10, out_valid10, out_sat10;
    logic signed [9:0]  out_data10;
    logic [3:0]         out_beats10;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 0;

    case_4_acc_frame #(.PROD_WIDTH(9), .ACC_WIDTH(16), .FRAME_LEN(FRAME_LEN)) dut16 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready16), .out_data(out_data16), .out_sat(out_sat16),
        .out_beats(out_beats16), .out_valid(out_valid16), .out_ready(out_ready));

    case_4_acc_frame #(.PROD_WIDTH(9), .ACC_WIDTH(10), .FRAME_LEN(FRAME_LEN)) dut10 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready10), .out_data(out_data10), .out_sat(out_sat10),
        .out_beats(out_beats10), .out_valid(out_valid10), .out_ready(out_ready));

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Clamp to the signed range of w bits, or wrap, depending on build.
    function automatic int fold(input int s, input int w, output bit hit);
        int hi, lo, v;
        hi  = (1 << (w - 1)) - 1;
        lo  = -(1 << (w - 1));
        hit = 1'b0;
`ifdef CASE4_ACC_SAT_EN
        v = s;
        if (s > hi) begin v = hi; hit = 1'b1; end
        if (s < lo) begin v = lo; hit = 1'b1; end
`else
        v = s & ((1 << w) - 1);
        if (v > hi) v = v - (1 << w);
`endif
        return v;
    endfunction

    // Model: running integer sums plus a pending-result flag.
    bit m_pend = 0;
    int m_acc16 = 0, m_acc10 = 0, m_cnt = 0;
    bit m_sat16 = 0, m_sat10 = 0;
    int e16 = 0, e10 = 0, e_beats = 0;
    bit e_sat16 = 0, e_sat10 = 0;

    always @(posedge ap_clk) begin
        bit hit;
        if (!ap_rst_n) begin
            m_pend = 0; m_acc16 = 0; m_acc10 = 0; m_cnt = 0; m_sat16 = 0; m_sat10 = 0;
        end else if (m_pend) begin
            if (out_ready) m_pend = 0;
        end else if (in_valid) begin
            m_acc16 = fold(m_acc16 + int'(in_data), 16, hit); m_sat16 |= hit;
            m_acc10 = fold(m_acc10 + int'(in_data), 10, hit); m_sat10 |= hit;
            m_cnt++;
            if (in_last || m_cnt == FRAME_LEN) begin
                e16 = m_acc16; e10 = m_acc10; e_beats = m_cnt;
                e_sat16 = m_sat16; e_sat10 = m_sat10;
                m_acc16 = 0; m_acc10 = 0; m_cnt = 0; m_sat16 = 0; m_sat10 = 0;
                m_pend = 1;
            end
        end
    end

    always @(negedge ap_clk) begin
        if (chk_en) begin
            check("in_ready16", int'(in_ready16), int'(!m_pend));
            check("out_valid16", int'(out_valid16), int'(m_pend));
            check("in_ready10", int'(in_ready10), int'(!m_pend));
            check("out_valid10", int'(out_valid10), int'(m_pend));
            if (m_pend) begin
                check("out_data16", int'(out_data16), e16);
                check("out_data10", int'(out_data10), e10);
                check("out_beats16", int'(out_beats16), e_beats);
                check("out_beats10", int'(out_beats10), e_beats);
                check("out_sat16", int'(out_sat16), int'(e_sat16));
                check("out_sat10", int'(out_sat10), int'(e_sat10));
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic beat(input int d, input bit last);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = 9'(d);
        in_last  = last;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready16;
            tick();
        end
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL beat_accept_timeout: data %0d never accepted", d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        tick();
        chk_en = 1;
        tick();
        check("rst_in_ready", int'(in_ready16), 1);
        check("rst_out_valid", int'(out_valid16), 0);
        check("rst_out_data", int'(out_data16), 0);
        check("rst_out_beats", int'(out_beats16), 0);
        check("rst_out_sat", int'(out_sat16), 0);
        ap_rst_n = 1'b1;
        tick();

        // Eight beats of +127 close on the length limit.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(127, 1'b0);
        check("t1_valid", int'(out_valid16), 1);
        check("t1_data", int'(out_data16), 1016);
        check("t1_beats", int'(out_beats16), 8);
        check("t1_sat", int'(out_sat16), 0);
        check("t1_in_ready", int'(in_ready16), 0);
        out_ready = 1'b1;
        tick();

        // Short frame, then five stalled cycles with a beat offered.
        out_ready = 1'b0;
        beat(-254, 1'b0); beat(100, 1'b0); beat(-3, 1'b1);
        check("t2_data", int'(out_data16), -157);
        check("t2_beats", int'(out_beats16), 3);
        in_valid = 1'b1; in_data = 9'sd55;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_data", int'(out_data16), -157);
            check("t2_hold_in_ready", int'(in_ready16), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t2_release_in_ready", int'(in_ready16), 1);

        // Overflow in the 10-bit instance.
        out_ready = 1'b0;
        beat(-254, 1'b0); beat(-254, 1'b0); beat(-254, 1'b0); beat(127, 1'b1);
`ifdef CASE4_ACC_SAT_EN
        check("t3_data10", int'(out_data10), -385);
        check("t3_sat10", int'(out_sat10), 1);
`else
        check("t3_data10", int'(out_data10), 389);
        check("t3_sat10", int'(out_sat10), 0);
`endif
        check("t3_data16", int'(out_data16), -635);
        out_ready = 1'b1;
        tick();

        // in_last coinciding with the length limit closes exactly one frame.
        for (int i = 0; i < 8; i++) beat(1, i == 7);
        check("t4_beats", int'(out_beats16), 8);
        check("t4_data", int'(out_data16), 8);
        tick();
        check("t4_no_empty_frame", int'(out_valid16), 0);
        beat(5, 1'b1);
        check("t4_fresh_data", int'(out_data16), 5);
        check("t4_fresh_beats", int'(out_beats16), 1);
        tick();

        // Reset mid-frame discards the partial sum.
        beat(10, 1'b0); beat(10, 1'b0); beat(10, 1'b0);
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        check("t5_rst_out_valid", int'(out_valid16), 0);
        beat(5, 1'b0); beat(5, 1'b1);
        check("t5_data", int'(out_data16), 10);
        check("t5_beats", int'(out_beats16), 2);
        tick();

        // Random traffic with random backpressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 9'($urandom_range(0, 511));
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            ap_rst_n  = ($urandom_range(0, 399) != 0);
            tick();
        end
        in_valid = 1'b0;
        ap_rst_n = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
